// File: rtl/rgb_csc_pkg.sv
// Shared definitions for the RGB colour-space converter pipe:
// mode encodings, fixed-point format, BT.601 coefficients and pipe latency.
package rgb_csc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GREY = 2'd1,
    MODE_YCC  = 2'd2,
    MODE_BIN  = 2'd3
  } mode_e;

  localparam int FRAC_BITS = 8;
  localparam int LAT       = 4;

  localparam int COEF_YR  = 76;
  localparam int COEF_YG  = 150;
  localparam int COEF_YB  = 30;
  localparam int COEF_CBR = -43;
  localparam int COEF_CBG = -85;
  localparam int COEF_CBB = 128;
  localparam int COEF_CRR = 128;
  localparam int COEF_CRG = -107;
  localparam int COEF_CRB = -21;

  // Bit positions inside the packed {clk_ce, de, vs, hs} sideband word
  localparam int SB_CE = 3;
  localparam int SB_DE = 2;
  localparam int SB_VS = 1;
  localparam int SB_HS = 0;

endpackage

// File: rtl/csc_dot3.sv
// One output channel of the converter: three signed products, a rounded
// sum, then an arithmetic shift, offset and clamp back to COMP_W bits.
// Two register stages inside; the clamped result is combinational so the
// parent can register it together with its output mux.
module csc_dot3
  import rgb_csc_pkg::*;
#(
  parameter int COMP_W = 8,
  parameter int COEF0  = 0,
  parameter int COEF1  = 0,
  parameter int COEF2  = 0,
  parameter int OFS    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [COMP_W-1:0] i_c0,
  input  logic [COMP_W-1:0] i_c1,
  input  logic [COMP_W-1:0] i_c2,
  output logic [COMP_W-1:0] o_res
);

  // COMP_W+11 bits hold the largest possible |sum| of three products plus rounding
  localparam int AW = COMP_W + 11;

  localparam logic signed [AW-1:0] K0   = AW'(COEF0);
  localparam logic signed [AW-1:0] K1   = AW'(COEF1);
  localparam logic signed [AW-1:0] K2   = AW'(COEF2);
  localparam logic signed [AW-1:0] RND  = AW'(1 << (FRAC_BITS - 1));
  localparam logic signed [AW-1:0] OFSV = AW'(OFS);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << COMP_W) - 1);

  logic signed [AW-1:0] w_x0, w_x1, w_x2;
  logic signed [AW-1:0] r_p0, r_p1, r_p2;
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_shift, w_ofs;

  assign w_x0 = signed'(AW'(i_c0));
  assign w_x1 = signed'(AW'(i_c1));
  assign w_x2 = signed'(AW'(i_c2));

  // Products of the unsigned components with the signed coefficients
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p0 <= '0;
      r_p1 <= '0;
      r_p2 <= '0;
    end else begin
      r_p0 <= w_x0 * K0;
      r_p1 <= w_x1 * K1;
      r_p2 <= w_x2 * K2;
    end
  end

  // Sum of products with half-LSB rounding bias
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else begin
      r_acc <= r_p0 + r_p1 + r_p2 + RND;
    end
  end

  assign w_shift = r_acc >>> FRAC_BITS;
  assign w_ofs   = w_shift + OFSV;

  // Saturate the offset result into the unsigned component range
  always_comb begin
    o_res = w_ofs[COMP_W-1:0];
    if (w_ofs[AW-1]) begin
      o_res = '0;
    end else if (w_ofs > MAXV) begin
      o_res = MAXV[COMP_W-1:0];
    end
  end

endmodule

// File: rtl/rgb_csc_pipe.sv
// RGB888 colour-space converter between CMOS capture and VDMA write.
// Pass / grey / YCbCr 4:4:4 / binary, selected per frame at the vs_i rising
// edge, with a fixed 4-cycle latency for data and sideband alike.
// Optional feature macro: RGB_CSC_BINARY_EN (threshold latch and mode 3
// thresholding; without it mode 3 renders as grey).
module rgb_csc_pipe
  import rgb_csc_pkg::*;
#(
  parameter int         COMP_W   = 8,
  parameter logic [1:0] MODE_RST = 2'd1
) (
  input  logic                cmos_pclk_i,
  input  logic                rst_i,
  input  logic [3*COMP_W-1:0] rgb_i,
  input  logic                clk_ce_i,
  input  logic                de_i,
  input  logic                vs_i,
  input  logic                hs_i,
  input  logic [1:0]          mode_i,
  input  logic [COMP_W-1:0]   thresh_i,
  output logic [3*COMP_W-1:0] pix_o,
  output logic                clk_ce_o,
  output logic                de_o,
  output logic                vs_o,
  output logic                hs_o,
  output logic [1:0]          mode_o
);

  localparam int PW = 3 * COMP_W;

  logic          r_vsD;
  logic          r_armed;
  mode_e         r_modeAct;
  logic          w_fs;
  mode_e         w_modeTag;

  logic [PW-1:0] r_rgb1, r_rgb2, r_rgb3;
  logic [3:0]    r_side1, r_side2, r_side3;
  mode_e         r_mode1, r_mode2, r_mode3;

  logic [COMP_W-1:0] w_y, w_cb, w_cr;
  logic [PW-1:0]     w_pix;

`ifdef RGB_CSC_BINARY_EN
  logic [COMP_W-1:0] r_thrAct;
  logic [COMP_W-1:0] w_thrTag;
  logic [COMP_W-1:0] r_thr1, r_thr2, r_thr3;
`else
  logic w_unusedThr;
  assign w_unusedThr = ^thresh_i;
`endif

  // r_armed blocks a false frame start when vs_i is already high at reset release
  assign w_fs      = vs_i & ~r_vsD & r_armed;
  assign w_modeTag = w_fs ? mode_e'(mode_i) : r_modeAct;
`ifdef RGB_CSC_BINARY_EN
  assign w_thrTag  = w_fs ? thresh_i : r_thrAct;
`endif

  // Frame-start detection and per-frame latch of mode and threshold
  always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vsD     <= 1'b0;
      r_armed   <= 1'b0;
      r_modeAct <= mode_e'(MODE_RST);
`ifdef RGB_CSC_BINARY_EN
      r_thrAct  <= '0;
`endif
    end else begin
      r_vsD   <= vs_i;
      r_armed <= 1'b1;
      if (w_fs) begin
        r_modeAct <= mode_e'(mode_i);
`ifdef RGB_CSC_BINARY_EN
        r_thrAct  <= thresh_i;
`endif
      end
    end
  end

  assign mode_o = r_modeAct;

  // Input register plus delay lines carrying raw pixel, sideband and tags
  always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rgb1  <= '0;
      r_rgb2  <= '0;
      r_rgb3  <= '0;
      r_side1 <= '0;
      r_side2 <= '0;
      r_side3 <= '0;
      r_mode1 <= MODE_PASS;
      r_mode2 <= MODE_PASS;
      r_mode3 <= MODE_PASS;
`ifdef RGB_CSC_BINARY_EN
      r_thr1  <= '0;
      r_thr2  <= '0;
      r_thr3  <= '0;
`endif
    end else begin
      r_rgb1  <= rgb_i;
      r_rgb2  <= r_rgb1;
      r_rgb3  <= r_rgb2;
      r_side1 <= {clk_ce_i, de_i, vs_i, hs_i};
      r_side2 <= r_side1;
      r_side3 <= r_side2;
      r_mode1 <= w_modeTag;
      r_mode2 <= r_mode1;
      r_mode3 <= r_mode2;
`ifdef RGB_CSC_BINARY_EN
      r_thr1  <= w_thrTag;
      r_thr2  <= r_thr1;
      r_thr3  <= r_thr2;
`endif
    end
  end

  csc_dot3 #(
    .COMP_W(COMP_W), .COEF0(COEF_YR), .COEF1(COEF_YG), .COEF2(COEF_YB), .OFS(0)
  ) u_dotY (
    .i_clk(cmos_pclk_i), .i_rst(rst_i),
    .i_c0(r_rgb1[PW-1 -: COMP_W]), .i_c1(r_rgb1[2*COMP_W-1 -: COMP_W]),
    .i_c2(r_rgb1[COMP_W-1:0]), .o_res(w_y)
  );

  csc_dot3 #(
    .COMP_W(COMP_W), .COEF0(COEF_CBR), .COEF1(COEF_CBG), .COEF2(COEF_CBB),
    .OFS(1 << (COMP_W - 1))
  ) u_dotCb (
    .i_clk(cmos_pclk_i), .i_rst(rst_i),
    .i_c0(r_rgb1[PW-1 -: COMP_W]), .i_c1(r_rgb1[2*COMP_W-1 -: COMP_W]),
    .i_c2(r_rgb1[COMP_W-1:0]), .o_res(w_cb)
  );

  csc_dot3 #(
    .COMP_W(COMP_W), .COEF0(COEF_CRR), .COEF1(COEF_CRG), .COEF2(COEF_CRB),
    .OFS(1 << (COMP_W - 1))
  ) u_dotCr (
    .i_clk(cmos_pclk_i), .i_rst(rst_i),
    .i_c0(r_rgb1[PW-1 -: COMP_W]), .i_c1(r_rgb1[2*COMP_W-1 -: COMP_W]),
    .i_c2(r_rgb1[COMP_W-1:0]), .o_res(w_cr)
  );

  // Output selection by each pixel's own mode tag; blanked outside active video
  always_comb begin
    w_pix = '0;
    if (r_side3[SB_DE]) begin
      case (r_mode3)
        MODE_PASS: w_pix = r_rgb3;
        MODE_YCC:  w_pix = {w_y, w_cb, w_cr};
`ifdef RGB_CSC_BINARY_EN
        MODE_BIN:  w_pix = (w_y >= r_thr3) ? {PW{1'b1}} : {PW{1'b0}};
`endif
        default:   w_pix = {w_y, w_y, w_y};
      endcase
    end
  end

  // Final output register for pixel and untouched sideband
  always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_o    <= '0;
      clk_ce_o <= 1'b0;
      de_o     <= 1'b0;
      vs_o     <= 1'b0;
      hs_o     <= 1'b0;
    end else begin
      pix_o    <= w_pix;
      clk_ce_o <= r_side3[SB_CE];
      de_o     <= r_side3[SB_DE];
      vs_o     <= r_side3[SB_VS];
      hs_o     <= r_side3[SB_HS];
    end
  end

endmodule

// File: tb/tb_rgb_csc_pipe.sv
// Self-checking bench for rgb_csc_pipe (COMP_W=8, MODE_RST=1).
// Expected results come from an arithmetic model of the conversion rules and
// a per-frame mode/threshold latch; outputs are recorded per cycle and
// compared 4 cycles after the corresponding input.
module tb_rgb_csc_pipe;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rgbIn;
  logic        ceIn, deIn, vsIn, hsIn;
  logic [1:0]  modeIn;
  logic [7:0]  thrIn;
  logic [23:0] pixOut;
  logic        ceOut, deOut, vsOut, hsOut;
  logic [1:0]  modeOut;

  logic [27:0] expOut  [N];
  logic [27:0] obsOut  [N];
  logic [1:0]  expMode [N];
  logic [1:0]  obsMode [N];

  int stepCnt  = 0;
  int checks   = 0;
  int failures = 0;

  logic [1:0] mAct;
  logic [7:0] mThr;
  logic       mPrevVs;

  rgb_csc_pipe #(.COMP_W(8), .MODE_RST(2'd1)) dut (
    .cmos_pclk_i(clk), .rst_i(rst), .rgb_i(rgbIn),
    .clk_ce_i(ceIn), .de_i(deIn), .vs_i(vsIn), .hs_i(hsIn),
    .mode_i(modeIn), .thresh_i(thrIn),
    .pix_o(pixOut), .clk_ce_o(ceOut), .de_o(deOut), .vs_o(vsOut), .hs_o(hsOut),
    .mode_o(modeOut)
  );

  // Free-running pixel clock
  always #5 clk = ~clk;

  function automatic int clampC(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Reference conversion of one pixel
  function automatic logic [23:0] refPix(input logic [23:0] rgb, input logic de,
                                         input logic [1:0] mode, input logic [7:0] thr);
    int r, g, b, y, cb, cr;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    y  = clampC((76 * r + 150 * g + 30 * b + 128) >>> 8);
    cb = clampC(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128);
    cr = clampC(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128);
    if (!de) return 24'h0;
    case (mode)
      2'd0: return rgb;
      2'd2: return {8'(y), 8'(cb), 8'(cr)};
`ifdef RGB_CSC_BINARY_EN
      2'd3: return (y >= int'(thr)) ? 24'hFFFFFF : 24'h000000;
`endif
      default: return {8'(y), 8'(y), 8'(y)};
    endcase
  endfunction

  // After reset the pipe holds nothing and a level already high on vs is not a frame start
  task automatic modelReset();
    mAct    = 2'd1;
    mThr    = 8'd0;
    mPrevVs = 1'b1;
    for (int j = 0; j < 3; j++) expOut[stepCnt + j] = 28'h0;
  endtask

  // Drive one pixel cycle, advance the model, record what the DUT shows after the edge
  task automatic applyStimulus(input logic [23:0] rgb, input logic ce, input logic de,
                               input logic vs, input logic hs,
                               input logic [1:0] mode, input logic [7:0] thr);
    if (stepCnt + 3 >= N) begin
      $display("[TB] FAIL step_budget got=%0d want<%0d", stepCnt, N - 3);
      $fatal(1, "[TB] step budget exhausted");
    end
    if (vs && !mPrevVs) begin
      mAct = mode;
      mThr = thr;
    end
    mPrevVs = vs;
    expOut[stepCnt + 3] = {refPix(rgb, de, mAct, mThr), ce, de, vs, hs};
    expMode[stepCnt]    = mAct;
    rgbIn = rgb; ceIn = ce; deIn = de; vsIn = vs; hsIn = hs;
    modeIn = mode; thrIn = thr;
    @(posedge clk);
    #1;
    obsOut[stepCnt]  = {pixOut, ceOut, deOut, vsOut, hsOut};
    obsMode[stepCnt] = modeOut;
    stepCnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rgbIn = 24'h0; ceIn = 0; deIn = 0; vsIn = 0; hsIn = 0; modeIn = 2'd0; thrIn = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pixOut !== 24'h0) begin
      failures++; $display("[TB] FAIL reset.pix got=%h want=000000", pixOut);
    end
    checks++;
    if ({ceOut, deOut, vsOut, hsOut} !== 4'h0) begin
      failures++; $display("[TB] FAIL reset.side got=%b want=0000", {ceOut, deOut, vsOut, hsOut});
    end
    checks++;
    if (modeOut !== 2'd1) begin
      failures++; $display("[TB] FAIL reset.mode got=%0d want=1", modeOut);
    end
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_grey();
    int s0, k;
    s0 = stepCnt;
    applyStimulus(24'h123456, 1, 0, 0, 0, 2'd1, 8'd0);
    k = stepCnt;
    applyStimulus(24'hFF0000, 1, 1, 1, 1, 2'd1, 8'd0);
    applyStimulus(24'hFFFFFF, 1, 1, 1, 1, 2'd1, 8'd0);
    repeat (3) applyStimulus(24'hABCDEF, 1, 0, 1, 0, 2'd1, 8'd0);
    checks++;
    if (obsOut[k + 2][27:4] !== 24'h0) begin
      failures++; $display("[TB] FAIL grey.latency got=%h want=000000", obsOut[k + 2][27:4]);
    end
    checks++;
    if (obsOut[k + 3][27:4] !== 24'h4C4C4C) begin
      failures++; $display("[TB] FAIL grey.red got=%h want=4c4c4c", obsOut[k + 3][27:4]);
    end
    checks++;
    if (obsOut[k + 4][27:4] !== 24'hFFFFFF) begin
      failures++; $display("[TB] FAIL grey.white got=%h want=ffffff", obsOut[k + 4][27:4]);
    end
    for (int j = s0; j < stepCnt; j++) begin
      checks++;
      if (obsOut[j] !== expOut[j]) begin
        failures++; $display("[TB] FAIL grey.pipe step=%0d got=%h want=%h", j, obsOut[j], expOut[j]);
      end
      checks++;
      if (obsMode[j] !== expMode[j]) begin
        failures++; $display("[TB] FAIL grey.mode step=%0d got=%0d want=%0d", j, obsMode[j], expMode[j]);
      end
    end
  endtask

  task automatic test_ycc();
    int s0, k;
    s0 = stepCnt;
    applyStimulus(24'h0, 1, 0, 0, 0, 2'd2, 8'd0);
    k = stepCnt;
    applyStimulus(24'hFF0000, 1, 1, 1, 1, 2'd2, 8'd0);
    applyStimulus(24'hFFFFFF, 1, 1, 1, 1, 2'd2, 8'd0);
    applyStimulus(24'h00FF00, 1, 1, 1, 1, 2'd2, 8'd0);
    repeat (3) applyStimulus(24'h0, 1, 0, 1, 0, 2'd2, 8'd0);
    checks++;
    if (obsOut[k + 3][27:4] !== 24'h4C55FF) begin
      failures++; $display("[TB] FAIL ycc.red got=%h want=4c55ff", obsOut[k + 3][27:4]);
    end
    checks++;
    if (obsOut[k + 4][27:4] !== 24'hFF8080) begin
      failures++; $display("[TB] FAIL ycc.white got=%h want=ff8080", obsOut[k + 4][27:4]);
    end
    for (int j = s0; j < stepCnt; j++) begin
      checks++;
      if (obsOut[j] !== expOut[j]) begin
        failures++; $display("[TB] FAIL ycc.pipe step=%0d got=%h want=%h", j, obsOut[j], expOut[j]);
      end
      checks++;
      if (obsMode[j] !== expMode[j]) begin
        failures++; $display("[TB] FAIL ycc.mode step=%0d got=%0d want=%0d", j, obsMode[j], expMode[j]);
      end
    end
  endtask

  task automatic test_mode_switch();
    int s0, k1, kf;
    s0 = stepCnt;
    applyStimulus(24'h0, 1, 0, 0, 0, 2'd1, 8'd0);
    applyStimulus(24'h808080, 1, 1, 1, 1, 2'd1, 8'd0);
    k1 = stepCnt;
    applyStimulus(24'hFF0000, 1, 1, 1, 1, 2'd2, 8'd0);
    applyStimulus(24'hFFFFFF, 1, 1, 1, 1, 2'd2, 8'd0);
    applyStimulus(24'h0, 1, 0, 0, 0, 2'd0, 8'd0);
    kf = stepCnt;
    applyStimulus(24'hFF0000, 1, 1, 1, 1, 2'd2, 8'd0);
    applyStimulus(24'hFFFFFF, 1, 1, 1, 1, 2'd1, 8'd0);
    repeat (3) applyStimulus(24'h0, 1, 0, 1, 0, 2'd1, 8'd0);
    checks++;
    if (obsOut[k1 + 3][27:4] !== 24'h4C4C4C) begin
      failures++; $display("[TB] FAIL switch.midframe got=%h want=4c4c4c", obsOut[k1 + 3][27:4]);
    end
    checks++;
    if (obsOut[kf + 3][27:4] !== 24'h4C55FF) begin
      failures++; $display("[TB] FAIL switch.newframe got=%h want=4c55ff", obsOut[kf + 3][27:4]);
    end
    checks++;
    if (obsOut[kf + 4][27:4] !== 24'hFF8080) begin
      failures++; $display("[TB] FAIL switch.holds got=%h want=ff8080", obsOut[kf + 4][27:4]);
    end
    checks++;
    if (obsMode[kf - 1] !== 2'd1 || obsMode[kf] !== 2'd2) begin
      failures++; $display("[TB] FAIL switch.mode_o got=%0d,%0d want=1,2", obsMode[kf - 1], obsMode[kf]);
    end
    for (int j = s0; j < stepCnt; j++) begin
      checks++;
      if (obsOut[j] !== expOut[j]) begin
        failures++; $display("[TB] FAIL switch.pipe step=%0d got=%h want=%h", j, obsOut[j], expOut[j]);
      end
      checks++;
      if (obsMode[j] !== expMode[j]) begin
        failures++; $display("[TB] FAIL switch.mode step=%0d got=%0d want=%0d", j, obsMode[j], expMode[j]);
      end
    end
  endtask

  task automatic test_binary();
    int s0, k;
    logic [23:0] want99, want100;
`ifdef RGB_CSC_BINARY_EN
    want99 = 24'h000000; want100 = 24'hFFFFFF;
`else
    want99 = 24'h636363; want100 = 24'h646464;
`endif
    s0 = stepCnt;
    applyStimulus(24'h0, 1, 0, 0, 0, 2'd3, 8'd100);
    k = stepCnt;
    applyStimulus(24'h636363, 1, 1, 1, 1, 2'd3, 8'd100);
    applyStimulus(24'h646464, 1, 1, 1, 1, 2'd0, 8'd200);
    repeat (3) applyStimulus(24'h0, 1, 0, 1, 0, 2'd0, 8'd200);
    checks++;
    if (obsOut[k + 3][27:4] !== want99) begin
      failures++; $display("[TB] FAIL binary.below got=%h want=%h", obsOut[k + 3][27:4], want99);
    end
    checks++;
    if (obsOut[k + 4][27:4] !== want100) begin
      failures++; $display("[TB] FAIL binary.equal got=%h want=%h", obsOut[k + 4][27:4], want100);
    end
    checks++;
    if (obsMode[k] !== 2'd3) begin
      failures++; $display("[TB] FAIL binary.mode_o got=%0d want=3", obsMode[k]);
    end
    for (int j = s0; j < stepCnt; j++) begin
      checks++;
      if (obsOut[j] !== expOut[j]) begin
        failures++; $display("[TB] FAIL binary.pipe step=%0d got=%h want=%h", j, obsOut[j], expOut[j]);
      end
      checks++;
      if (obsMode[j] !== expMode[j]) begin
        failures++; $display("[TB] FAIL binary.mode step=%0d got=%0d want=%0d", j, obsMode[j], expMode[j]);
      end
    end
  endtask

  task automatic test_sideband();
    int s0, k;
    logic [3:0] side [8];
    s0 = stepCnt;
    k  = stepCnt;
    for (int i = 0; i < 8; i++) begin
      side[i] = 4'($urandom_range(0, 15)) & 4'b1011;
      applyStimulus(24'($urandom) | 24'h010101, side[i][3], 1'b0, side[i][1], side[i][0],
                    2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    repeat (3) applyStimulus(24'h0, 0, 0, 0, 0, 2'd0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obsOut[k + 3 + i] !== {24'h0, side[i]}) begin
        failures++;
        $display("[TB] FAIL sideband.blank i=%0d got=%h want=%h", i, obsOut[k + 3 + i], {24'h0, side[i]});
      end
    end
    for (int j = s0; j < stepCnt; j++) begin
      checks++;
      if (obsOut[j] !== expOut[j]) begin
        failures++; $display("[TB] FAIL sideband.pipe step=%0d got=%h want=%h", j, obsOut[j], expOut[j]);
      end
      checks++;
      if (obsMode[j] !== expMode[j]) begin
        failures++; $display("[TB] FAIL sideband.mode step=%0d got=%0d want=%0d", j, obsMode[j], expMode[j]);
      end
    end
  endtask

  task automatic test_random();
    int s0;
    logic vsState;
    s0 = stepCnt;
    vsState = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) vsState = ~vsState;
      applyStimulus(24'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), vsState, 1'($urandom),
                    2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    for (int j = s0; j < stepCnt; j++) begin
      checks++;
      if (obsOut[j] !== expOut[j]) begin
        failures++; $display("[TB] FAIL random.pipe step=%0d got=%h want=%h", j, obsOut[j], expOut[j]);
      end
      checks++;
      if (obsMode[j] !== expMode[j]) begin
        failures++; $display("[TB] FAIL random.mode step=%0d got=%0d want=%0d", j, obsMode[j], expMode[j]);
      end
    end
  endtask

  task automatic test_reset_midline();
    int s0, kr, kf;
    s0 = stepCnt;
    applyStimulus(24'h0, 1, 0, 0, 0, 2'd2, 8'd0);
    repeat (4) applyStimulus(24'hFF0000, 1, 1, 1, 1, 2'd2, 8'd0);
    rst = 1'b1;
    #1;
    checks++;
    if ({pixOut, ceOut, deOut, vsOut, hsOut} !== 28'h0) begin
      failures++; $display("[TB] FAIL midreset.async got=%h want=0", {pixOut, ceOut, deOut, vsOut, hsOut});
    end
    checks++;
    if (modeOut !== 2'd1) begin
      failures++; $display("[TB] FAIL midreset.mode got=%0d want=1", modeOut);
    end
    vsIn = 1'b1; deIn = 1'b1; modeIn = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pixOut, ceOut, deOut, vsOut, hsOut} !== 28'h0) begin
      failures++; $display("[TB] FAIL midreset.held got=%h want=0", {pixOut, ceOut, deOut, vsOut, hsOut});
    end
    rst = 1'b0;
    modelReset();
    kr = stepCnt;
    repeat (4) applyStimulus(24'hFF0000, 1, 1, 1, 1, 2'd2, 8'd0);
    applyStimulus(24'h0, 1, 0, 0, 0, 2'd2, 8'd0);
    kf = stepCnt;
    applyStimulus(24'hFF0000, 1, 1, 1, 1, 2'd2, 8'd0);
    repeat (3) applyStimulus(24'h0, 1, 0, 1, 0, 2'd2, 8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obsOut[kr + i] !== 28'h0) begin
        failures++; $display("[TB] FAIL midreset.flush i=%0d got=%h want=0", i, obsOut[kr + i]);
      end
    end
    checks++;
    if (obsMode[kr + 3] !== 2'd1 || obsOut[kr + 3][27:4] !== 24'h4C4C4C) begin
      failures++;
      $display("[TB] FAIL midreset.nolatch got=mode%0d/%h want=mode1/4c4c4c", obsMode[kr + 3], obsOut[kr + 3][27:4]);
    end
    checks++;
    if (obsMode[kf] !== 2'd2 || obsOut[kf + 3][27:4] !== 24'h4C55FF) begin
      failures++;
      $display("[TB] FAIL midreset.relatch got=mode%0d/%h want=mode2/4c55ff", obsMode[kf], obsOut[kf + 3][27:4]);
    end
    for (int j = s0; j < stepCnt; j++) begin
      checks++;
      if (obsOut[j] !== expOut[j]) begin
        failures++; $display("[TB] FAIL midreset.pipe step=%0d got=%h want=%h", j, obsOut[j], expOut[j]);
      end
      checks++;
      if (obsMode[j] !== expMode[j]) begin
        failures++; $display("[TB] FAIL midreset.mode step=%0d got=%0d want=%0d", j, obsMode[j], expMode[j]);
      end
    end
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    test_reset();
    test_grey();
    test_ycc();
    test_mode_switch();
    test_binary();
    test_sideband();
    test_random();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_csc_pipe.md
# rgb_csc_pipe

Parametrised, mode-switchable colour-space converter for the CMOS capture path. It sits between the OV5640 RGB888 capture stage and the VDMA write path. Each pixel is either passed through or converted to replicated grey, YCbCr 4:4:4 (BT.601 integer coefficients), or thresholded binary. Mode and threshold are latched only at frame start, so a frame is never mixed. Sync/enable sideband is delayed to match the data exactly.

## Interface
- COMP_W, 8: bits per colour component (8..10); pixel bus is 3*COMP_W.
- MODE_RST, 1: active mode after reset.
- cmos_pclk_i  in  1  pixel clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- rgb_i  in  3*COMP_W  {R,G,B}, R in MSBs.
- clk_ce_i / de_i / vs_i / hs_i  in  1 each  sideband, any polarity except vs_i (frame start = 0→1).
- mode_i  in  2  requested mode: 0 pass, 1 grey, 2 YCbCr, 3 binary.
- thresh_i  in  COMP_W  binary threshold on Y.
- pix_o  out  3*COMP_W  converted pixel.
- clk_ce_o / de_o / vs_o / hs_o  out  1 each  sideband delayed by LAT.
- mode_o  out  2  currently active mode.

## Operation
- Frame-start detect: vs_d <= vs_i; fs = vs_i & ~vs_d. On fs, active mode <= mode_i and active threshold <= thresh_i. Values take effect from the pixel presented in the same cycle as fs.
- Mode and threshold tags travel with each pixel through the pipe; output mux uses the pixel's own tag.
- Coefficients (FRAC=8, signed): Y = 76R+150G+30B; Cb = −43R−85G+128B; Cr = 128R−107G−21B.
- Per channel: acc = Σ coef·comp + 2^(FRAC−1). Result = acc >>> FRAC (arithmetic, floor).
- For Cb/Cr, add OFS = 2^(COMP_W−1), then clamp to [0, 2^COMP_W−1]. Y is also clamped.
- Accumulator width is COMP_W+11 signed; no intermediate overflow is permitted.
- Output by mode:
  - 0: rgb_i delayed unchanged.
  - 1: {Y,Y,Y}.
  - 2: {Y,Cb,Cr}.
  - 3: all-ones if Y ≥ thr, else zero.
- When the pixel's delayed de is 0, pix_o = 0. Sideband is never modified.
- Mode 3 without the macro: treated as mode 1.

## Timing
- LAT = 4 cycles, identical for every mode including passthrough.
- Stage 1: input register. Stage 2: products. Stage 3: sum + round. Stage 4: shift, offset, clamp, mux.
- One pixel per cycle. No backpressure. clk_ce_i does not stall the pipe; it is delayed like other sideband.
- Reset values: pix_o=0, clk_ce_o=0, de_o=0, vs_o=0, hs_o=0, mode_o=MODE_RST, active threshold=0. All pipeline stages and tags clear; vs_d=0.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, the first LAT output cycles are zero.
  - If vs_i is already high when reset releases, no fs is generated. MODE_RST remains active until the next 0→1 edge.
- fs coinciding with a mode_i change: the value sampled on the fs cycle wins.
- mode_o updates one cycle after fs and reflects input-side state, not output-side.

## Configuration
- RGB_CSC_BINARY_EN defined: mode 3 thresholding, threshold latch and tag compiled in.
- Not defined:
  - thresh_i is ignored and no threshold register exists.
  - mode 3 behaves exactly as mode 1.
  - mode_o still reports the latched value 3.

## Structure
- Package rgb_csc_pkg holds:
  - mode encodings (MODE_PASS/GREY/YCC/BIN);
  - FRAC_BITS=8;
  - the nine signed coefficient constants and LAT=4.
- Sub-module csc_dot3: one 3-term multiply/round/shift/offset/clamp pipe (parameters COMP_W, coefs, OFS). It is instantiated three times for Y, Cb and Cr.
- The top holds the input register, frame-start/mode latch, tag and sideband delay lines, and output mux.

## Test plan
- Grey mode, COMP_W=8, rgb=(255,0,0) → pix_o=(76,76,76) exactly 4 cycles later; (255,255,255) → (255,255,255).
- YCbCr, red (255,0,0) → Y=76, Cb=85, Cr=255 (clamped from 256); white → (255,128,128).
- Mode switch: set mode_i 1→2 mid-frame → output stays grey until the next vs_i rise; the first pixel after the rise is YCbCr; mode_o changes 1 cycle after fs.
- Binary (macro on), thresh=100: grey-level pixels 99/100 → 0x000000/0xFFFFFF. With the macro off, the same stimulus gives grey 99/100.
- de_i=0 with nonzero rgb_i → pix_o=0; sideband pattern on clk_ce/de/vs/hs reproduced bit-exact at +4 cycles.
- Assert rst_i mid-line → all outputs 0 immediately, mode_o=MODE_RST. Release with vs_i high → no mode latch until the next 0→1 edge.
